// File: rtl/dtree_link_pkg.sv
// ============================================================================
// Module      : dtree_link_pkg
// Description : Shared definitions for the decision-tree feature link:
//               default widths, settle-time limit and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtree_link_pkg;

    localparam int FEAT_W_DEF  = 8;
    localparam int CLASS_W_DEF = 4;
    localparam int SETTLE_MAX  = 255;

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage : dtree_link_pkg

`default_nettype wire

// File: rtl/dtree_ser_shift.sv
// ============================================================================
// Module      : dtree_ser_shift
// Description : MSB-first serial-to-parallel shifter with bit counter.
//               o_word is the word that would be formed if the current bit
//               is taken; o_frame_done pulses while the last bit of a frame
//               is being accepted, so the caller can capture o_word on the
//               same edge.
// Ports       : clk, rst_n     - clock, async active-low reset
//               i_bit          - serial data bit
//               i_valid        - accept i_bit this cycle
//               o_word         - {history, i_bit}
//               o_frame_done   - FEAT_W-th bit accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtree_ser_shift
    import dtree_link_pkg::*;
#(
    parameter int FEAT_W = FEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bit,
    input  logic              i_valid,
    output logic [FEAT_W-1:0] o_word,
    output logic              o_frame_done
);

    localparam int               CNT_W  = (FEAT_W > 1) ? $clog2(FEAT_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FEAT_W - 1);

    // Only FEAT_W-1 bits of history are needed: the newest bit comes
    // straight from the input when the word is formed.
    logic [FEAT_W-2:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;

    assign o_word       = {r_sr, i_bit};
    assign o_frame_done = i_valid && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            r_sr <= o_word[FEAT_W-2:0];
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : dtree_ser_shift

`default_nettype wire

// File: rtl/dtree_feature_link.sv
// ============================================================================
// Module      : dtree_feature_link
// Description : Serial feature loader and result handshake around a purely
//               combinational printed decision tree. A feature is shifted in
//               MSB first, driven in parallel onto the tree, and after SETTLE
//               cycles the tree's class output is sampled and offered with a
//               valid/ready handshake.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_ser_in         - serial feature bit (MSB first)
//               i_ser_valid      - qualifies i_ser_in
//               o_feat_out       - parallel feature to the tree
//               i_class_in       - tree class output
//               o_res_class      - registered class result
//               o_res_valid      - result available
//               i_res_ready      - consumer accepts result
//               o_busy           - serial input not accepted
//               o_overrun        - sticky: bit arrived while busy
//               i_clr_overrun    - clears o_overrun
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtree_feature_link
    import dtree_link_pkg::*;
#(
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_ser_in,
    input  logic               i_ser_valid,
    output logic [FEAT_W-1:0]  o_feat_out,
    input  logic [CLASS_W-1:0] i_class_in,
    output logic [CLASS_W-1:0] o_res_class,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic               o_busy,
    output logic               o_overrun,
    input  logic               i_clr_overrun
);

    localparam logic [7:0] c_SETTLE = 8'(SETTLE);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_settle;
    logic [FEAT_W-1:0]  r_feat;
    logic [CLASS_W-1:0] r_class;
    logic               r_res_valid;
    logic               r_overrun;

    logic               w_busy;
    logic               w_accept;
    logic               w_sample;
    logic               w_release;
    logic               w_frame_done;
    logic [FEAT_W-1:0]  w_word;

    // Bits are only taken in SHIFT; anything offered while busy is dropped
    // and flagged, leaving the partial-frame counter untouched.
    assign w_accept = i_ser_valid && !w_busy;

    dtree_ser_shift #(
        .FEAT_W (FEAT_W)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bit        (i_ser_in),
        .i_valid      (w_accept),
        .o_word       (w_word),
        .o_frame_done (w_frame_done)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SHIFT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SHIFT:  if (w_frame_done)         w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle == 8'd1)     w_state_nxt = ST_HOLD;
            ST_HOLD:   if (i_res_ready)          w_state_nxt = ST_SHIFT;
            default:                             w_state_nxt = ST_SHIFT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy    = (r_state != ST_SHIFT);
        w_sample  = (r_state == ST_SETTLE) && (r_settle == 8'd1);
        w_release = (r_state == ST_HOLD) && i_res_ready;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat      <= '0;
            r_settle    <= '0;
            r_class     <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_feat   <= w_word;
                r_settle <= c_SETTLE;
            end else if ((r_state == ST_SETTLE) && (r_settle != 8'd0)) begin
                r_settle <= r_settle - 8'd1;
            end

            // The tree output is only trusted on the last settle cycle.
            if (w_sample) begin
                r_class     <= i_class_in;
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end

            // A new overrun event takes priority over a clear.
            if (i_ser_valid && w_busy) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_feat_out  = r_feat;
    assign o_res_class = r_class;
    assign o_res_valid = r_res_valid;
    assign o_busy      = w_busy;
    assign o_overrun   = r_overrun;

endmodule : dtree_feature_link

`default_nettype wire

// File: tb/tb_dtree_feature_link.sv
`default_nettype none

module tb_dtree_feature_link;

    typedef struct packed {
        logic [7:0] f;
        logic [3:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- DUT 1 (SETTLE=2) ----------------
    logic       ser_in = 1'b0, ser_valid = 1'b0, res_ready = 1'b0, clr = 1'b0;
    logic [7:0] feat_out;
    logic [3:0] class_in, res_class;
    logic       res_valid, busy, overrun;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_cls = 4'd0;

    // ---------------- DUT 2 (SETTLE=1, ready tied high) ----------------
    logic       ser_in2 = 1'b0, ser_valid2 = 1'b0, clr2 = 1'b0;
    logic       res_ready2 = 1'b1;
    logic [7:0] feat_out2;
    logic [3:0] class_in2, res_class2;
    logic       res_valid2, busy2, overrun2;

    // Small reference decision tree.
    function automatic logic [3:0] tree(input logic [7:0] f);
        if (f >= 8'h80) return f[2] ? 4'd7 : 4'd4;
        else            return (f >= 8'h30) ? 4'd2 : 4'd9;
    endfunction

    assign class_in  = ovr_en ? ovr_cls : tree(feat_out);
    assign class_in2 = tree(feat_out2);

    dtree_feature_link #(.FEAT_W(8), .CLASS_W(4), .SETTLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
        .o_feat_out(feat_out), .i_class_in(class_in), .o_res_class(res_class),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_busy(busy),
        .o_overrun(overrun), .i_clr_overrun(clr)
    );

    dtree_feature_link #(.FEAT_W(8), .CLASS_W(4), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_ser_in(ser_in2), .i_ser_valid(ser_valid2),
        .o_feat_out(feat_out2), .i_class_in(class_in2), .o_res_class(res_class2),
        .o_res_valid(res_valid2), .i_res_ready(res_ready2), .o_busy(busy2),
        .o_overrun(overrun2), .i_clr_overrun(clr2)
    );

    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected result", {24'd0, feat_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 res_class", {28'd0, res_class}, {28'd0, e.c});
                chk("dut1 feat_out@result", {24'd0, feat_out}, {24'd0, e.f});
            end
        end
    end

    int last_acc2 = -1;
    always @(negedge clk) begin
        if (rst_n && res_valid2 && res_ready2) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected result", {24'd0, feat_out2}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2 res_class", {28'd0, res_class2}, {28'd0, e.c});
                chk("dut2 feat_out@result", {24'd0, feat_out2}, {24'd0, e.f});
            end
            if (last_acc2 >= 0) chk("dut2 frame period", cyc - last_acc2, 32'd10);
            last_acc2 = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) begin
            ser_in    = f[i];
            ser_valid = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) begin
            ser_in2    = f[i];
            ser_valid2 = 1'b1;
            tick();
        end
        ser_valid2 = 1'b0;
    endtask

    task automatic wait_valid1(input string name, input int budget);
        int k;
        k = 0;
        while (!res_valid && k < budget) begin
            tick();
            k++;
        end
        if (!res_valid) chk({name, " timeout waiting res_valid"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle1(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        if (busy) chk({name, " timeout waiting idle"}, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] frames [4];
        frames[0] = 8'hA5; frames[1] = 8'h3C; frames[2] = 8'h12; frames[3] = 8'hC0;

        // Reset state
        tick(); tick();
        chk("reset feat_out", {24'd0, feat_out}, 32'd0);
        chk("reset res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic frame 0xA5 -> class 7, two-cycle settle
        q1.push_back('{f: 8'hA5, c: 4'd7});
        send1(8'hA5);
        chk("t1 feat_out at capture", {24'd0, feat_out}, 32'hA5);
        chk("t1 busy at capture", {31'd0, busy}, 32'd1);
        chk("t1 res_valid E0", {31'd0, res_valid}, 32'd0);
        tick();
        chk("t1 res_valid E0+1", {31'd0, res_valid}, 32'd0);
        chk("t1 busy E0+1", {31'd0, busy}, 32'd1);
        tick();
        chk("t1 res_valid E0+2", {31'd0, res_valid}, 32'd1);
        chk("t1 res_class E0+2", {28'd0, res_class}, 32'd7);
        res_ready = 1'b1;
        tick();
        chk("t1 res_valid after accept", {31'd0, res_valid}, 32'd0);
        chk("t1 busy after accept", {31'd0, busy}, 32'd0);
        res_ready = 1'b0;

        // 2: gapped bits, feature 0x3C
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        q1.push_back('{f: 8'h3C, c: 4'd2});
        for (int i = 7; i >= 4; i--) begin
            ser_in = frames[1][i]; ser_valid = 1'b1; tick();
        end
        ser_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("t2 feat_out during gap", {24'd0, feat_out}, 32'd0);
        end
        for (int i = 3; i >= 0; i--) begin
            ser_in = frames[1][i]; ser_valid = 1'b1; tick();
        end
        ser_valid = 1'b0;
        chk("t2 feat_out at capture", {24'd0, feat_out}, 32'h3C);
        res_ready = 1'b1;
        wait_idle1("t2", 20);
        res_ready = 1'b0;

        // 3: long stall in HOLD, tree output changes underneath
        q1.push_back('{f: 8'hA5, c: 4'd7});
        send1(8'hA5);
        wait_valid1("t3", 10);
        ovr_en = 1'b1; ovr_cls = 4'd7;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) ovr_cls = 4'd2;
            tick();
            chk("t3 res_valid held", {31'd0, res_valid}, 32'd1);
            chk("t3 res_class held", {28'd0, res_class}, 32'd7);
        end
        res_ready = 1'b1;
        tick();
        chk("t3 res_valid drop", {31'd0, res_valid}, 32'd0);
        res_ready = 1'b0;
        ovr_en = 1'b0;

        // 4: overrun during HOLD
        q1.push_back('{f: 8'hA5, c: 4'd7});
        send1(8'hA5);
        wait_valid1("t4a", 10);
        ser_in = 1'b0;
        ser_valid = 1'b1;
        tick(); tick(); tick();
        ser_valid = 1'b0;
        chk("t4 overrun set", {31'd0, overrun}, 32'd1);
        res_ready = 1'b1;
        tick();
        q1.push_back('{f: 8'hFF, c: 4'd7});
        send1(8'hFF);
        chk("t4 feat_out 0xFF", {24'd0, feat_out}, 32'hFF);
        wait_idle1("t4b", 20);
        chk("t4 overrun sticky", {31'd0, overrun}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4 overrun cleared", {31'd0, overrun}, 32'd0);
        res_ready = 1'b0;
        q1.push_back('{f: 8'h3C, c: 4'd2});
        send1(8'h3C);
        wait_valid1("t4c", 10);
        clr = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
        tick();
        clr = 1'b0; ser_valid = 1'b0;
        chk("t4 set beats clear", {31'd0, overrun}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4 overrun cleared 2", {31'd0, overrun}, 32'd0);
        res_ready = 1'b1;
        wait_idle1("t4d", 20);
        res_ready = 1'b0;

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) begin
            ser_in = i[0]; ser_valid = 1'b1; tick();
        end
        ser_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5 async feat_out", {24'd0, feat_out}, 32'd0);
        chk("t5 async res_class", {28'd0, res_class}, 32'd0);
        chk("t5 async res_valid", {31'd0, res_valid}, 32'd0);
        chk("t5 async busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        q1.push_back('{f: 8'h81, c: 4'd4});
        send1(8'h81);
        chk("t5 feat_out 0x81", {24'd0, feat_out}, 32'h81);
        res_ready = 1'b1;
        wait_idle1("t5", 20);
        res_ready = 1'b0;

        // 6: back-to-back frames on the SETTLE=1 instance
        for (int n = 0; n < 4; n++) begin
            q2.push_back('{f: frames[n], c: tree(frames[n])});
            send2(frames[n]);
            tick(); tick();
        end
        for (int i = 0; i < 5; i++) tick();
        chk("t6 no overrun", {31'd0, overrun2}, 32'd0);
        chk("t6 idle", {31'd0, busy2}, 32'd0);

        chk("dut1 all results seen", q1.size(), 32'd0);
        chk("dut2 all results seen", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dtree_feature_link

`default_nettype wire
